// File: rtl/data_cache_pkg.sv
// Shared types and sizing for the direct-mapped, write-through data cache.
package cache_pkg;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BE_W        = WORD_W / 8;
  localparam int unsigned TAG_W       = 24;
  localparam int unsigned INDEX_BITS  = 4;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned LINE_WORDS  = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    word_t             wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

  // Replace only the byte lanes selected by be.
  function automatic word_t merge_bytes(word_t old_w, word_t new_w, logic [BE_W-1:0] be);
    word_t res;
    res = old_w;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction
endpackage

// File: rtl/data_cache_if.sv
// Datapath-side and memory-side signals of the data cache.
interface data_cache_if;
  import cache_pkg::*;

  logic                cpu_re;
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  word_t               cpu_wdata;
  logic [BE_W-1:0]     cpu_be;
  word_t               cpu_rdata;
  logic                stall;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  word_t               mem_wdata;
  logic [BE_W-1:0]     mem_be;
  logic                mem_ack;
  word_t               mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_ack, mem_rdata,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_ack, mem_rdata,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/data_cache_store.sv
// Tag, valid and data arrays: combinational read, byte-enabled word write.
module cache_store
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = cache_pkg::INDEX_BITS,
  parameter int unsigned TAG_BITS   = TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  index,
  input  logic [OFFSET_BITS-1:0] rd_off,
  output logic [TAG_BITS-1:0]    rd_tag_c,
  output logic                   rd_valid_c,
  output word_t                  rd_word_c,
  input  logic                   wr_en,
  input  logic [OFFSET_BITS-1:0] wr_off,
  input  word_t                  wr_data,
  input  logic [BE_W-1:0]        wr_be,
  input  logic                   fill_en,
  input  logic [TAG_BITS-1:0]    fill_tag
);
  localparam int unsigned SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  line_t               data_q [SETS];

  assign rd_valid_c = valid_q[index];
  assign rd_tag_c   = tag_q[index];
  assign rd_word_c  = data_q[index][rd_off];

  // Only the valid bits are reset; tag/data contents are qualified by them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag_q[index] <= fill_tag;
    if (wr_en)   data_q[index][wr_off] <= merge_bytes(data_q[index][wr_off], wr_data, wr_be);
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through/no-write-allocate data cache: FSM, refill counter, memory-side muxing.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = cache_pkg::INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus
);
  localparam int unsigned TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(LINE_WORDS - 1);

  state_t                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;

  logic [TAG_BITS-1:0]    req_tag, rd_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] req_off, wr_off;
  logic                   rd_valid, hit, is_store, is_load;
  word_t                  rd_word, wr_data;
  logic [BE_W-1:0]        wr_be;
  logic                   wr_en, fill_en;
  mem_cmd_t               cmd;
  logic                   unused_addr_lsb;

  assign req_tag         = bus.cpu_addr[ADDR_W-1 -: TAG_BITS];
  assign req_index       = bus.cpu_addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign req_off         = bus.cpu_addr[2 +: OFFSET_BITS];
  assign unused_addr_lsb = ^bus.cpu_addr[1:0];
  assign hit             = rd_valid && (rd_tag == req_tag);
  assign is_store        = bus.cpu_we;
  assign is_load         = bus.cpu_re && !bus.cpu_we;

  cache_store #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .index     (req_index),
    .rd_off    (req_off),
    .rd_tag_c  (rd_tag),
    .rd_valid_c(rd_valid),
    .rd_word_c (rd_word),
    .wr_en     (wr_en),
    .wr_off    (wr_off),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .fill_en   (fill_en),
    .fill_tag  (req_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and refill word counter; the counter wraps to 0 on the last ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (is_store) begin
          state_d = WRITE;
        end else if (is_load && !hit) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        if (bus.mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) state_d = IDLE;
        end
      end
      WRITE: begin
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath/memory outputs and array write controls.
  always_comb begin
    bus.stall     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.cpu_rdata = '0;
    cmd           = '0;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    wr_off        = req_off;
    wr_data       = bus.cpu_wdata;
    wr_be         = bus.cpu_be;
    case (state_q)
      IDLE: begin
        if (is_store) begin
          bus.stall = 1'b1;
        end else if (is_load) begin
          if (hit) bus.cpu_rdata = rd_word;
          else     bus.stall     = 1'b1;
        end
      end
      REFILL: begin
        bus.stall   = 1'b1;
        bus.mem_req = 1'b1;
        cmd.addr    = {req_tag, req_index, cnt_q, 2'b00};
        if (bus.mem_ack) begin
          wr_en   = 1'b1;
          wr_off  = cnt_q;
          wr_data = bus.mem_rdata;
          wr_be   = '1;
          fill_en = (cnt_q == LAST_WORD);
        end
      end
      WRITE: begin
        bus.stall   = !bus.mem_ack;
        bus.mem_req = 1'b1;
        cmd.we      = 1'b1;
        cmd.addr    = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
        cmd.wdata   = bus.cpu_wdata;
        cmd.be      = bus.cpu_be;
        wr_en       = bus.mem_ack && hit;
      end
      default: ;
    endcase
  end

  assign bus.mem_we    = cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.mem_be    = cmd.be;
endmodule
